difficulty_select: RTL and testbench

Conditions the five raw board push-buttons and produces the difficulty word that feeds the processor's difficulty input. The stages are:
- a two-flop synchronizer;
- a per-button debounce counter;
- a rising-edge press detector;
- a difficulty register with absolute selection (L/C/R) and step selection (U/D).

Changes are accepted only while the game is in its idle state, so difficulty cannot change mid-round.

---
 rtl/difficulty_select_pkg.sv | 13 +
 rtl/difficulty_select_button_debounce.sv | 38 +++
 rtl/difficulty_select.sv | 58 +++++
 tb/tb_difficulty_select.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/difficulty_select_pkg.sv
// difficulty_select_pkg: button indices, difficulty codes and idle game-state code shared with game-side blocks.
package difficulty_select_pkg;
   localparam int BTN_L = 0;
   localparam int BTN_C = 1;
   localparam int BTN_R = 2;
   localparam int BTN_U = 3;
   localparam int BTN_D = 4;
   typedef logic [1:0] diff_t;
   localparam diff_t DIFF_EASY = 2'd1;
   localparam diff_t DIFF_MED  = 2'd2;
   localparam diff_t DIFF_HARD = 2'd3;
   localparam logic [31:0] GAME_IDLE = 32'd0;
endpackage

// File: rtl/difficulty_select_button_debounce.sv
// button_debounce: two-flop synchronizer plus stable-count debouncer for one raw button.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W = 20
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic level
);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   logic sync1_q, sync2_q, level_q, level_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   always_comb begin
      level_d = level_q;
      cnt_d = cnt_q + 1'b1;
      if (sync2_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         level_d = sync2_q;
         cnt_d = '0;
      end
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q <= cnt_d;
      end
   end
   assign level = level_q;
endmodule

// File: rtl/difficulty_select.sv
// difficulty_select: debounces the five board buttons and maintains the 1..3 difficulty word,
// accepting changes only while the game is idle.
module difficulty_select
   import difficulty_select_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W = 20,
   parameter logic [31:0] IDLE_STATE = GAME_IDLE,
   parameter logic [31:0] DIFF_RESET = 32'd1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [4:0]  btn_raw,
   input  logic [31:0] game_state,
   output logic [31:0] difficulty,
   output logic [4:0]  btn_level,
   output logic [4:0]  press_pulse,
   output logic        difficulty_changed
);
   logic [4:0] prev_q;
   diff_t diff_q, diff_d;
   logic changed_q, changed_d;
   genvar i;
   for (i = 0; i < 5; i++) begin : g_btn
      button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
         .clock(clock),
         .reset(reset),
         .raw(btn_raw[i]),
         .level(btn_level[i])
      );
   end
   assign press_pulse = btn_level & ~prev_q;
   // Pulses outside idle are simply dropped; the chain encodes L > C > R > U > D.
   always_comb begin
      diff_d = diff_q;
      if (game_state == IDLE_STATE)
         diff_d = press_pulse[BTN_L] ? DIFF_EASY :
                  press_pulse[BTN_C] ? DIFF_MED  :
                  press_pulse[BTN_R] ? DIFF_HARD :
                  press_pulse[BTN_U] ? ((diff_q == DIFF_HARD) ? DIFF_HARD : diff_q + 2'd1) :
                  press_pulse[BTN_D] ? ((diff_q == DIFF_EASY) ? DIFF_EASY : diff_q - 2'd1) :
                  diff_q;
      changed_d = diff_d != diff_q;
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prev_q <= '0;
         diff_q <= DIFF_RESET[1:0];
         changed_q <= 1'b0;
      end else begin
         prev_q <= btn_level;
         diff_q <= diff_d;
         changed_q <= changed_d;
      end
   end
   assign difficulty = {30'd0, diff_q};
   assign difficulty_changed = changed_q;
endmodule

// File: tb/tb_difficulty_select.sv
// tb_difficulty_select: directed and randomized button scenarios checked against a
// sample-history reference model of the debounce and difficulty rules.
module tb_difficulty_select;
   localparam int D = 4;
   logic clk = 0;
   logic rst = 1;
   logic [4:0] btn_raw = '0;
   logic [31:0] game_state = '0;
   logic [31:0] difficulty;
   logic [4:0] btn_level, press_pulse;
   logic difficulty_changed;
   int n_chk = 0;
   int n_fail = 0;

   difficulty_select #(.DEBOUNCE_CYCLES(D), .CNT_W(4), .IDLE_STATE(32'd0), .DIFF_RESET(32'd1)) dut (
      .clock(clk),
      .reset(rst),
      .btn_raw(btn_raw),
      .game_state(game_state),
      .difficulty(difficulty),
      .btn_level(btn_level),
      .press_pulse(press_pulse),
      .difficulty_changed(difficulty_changed)
   );

   always #5 clk = ~clk;

   // Reference: a level flips once the last D values seen through the two-edge sync delay all disagree with it.
   logic [4:0] smp[$];
   logic [4:0] ev[$];
   logic [4:0] m_level = '0, m_prev = '0, m_pr;
   logic [1:0] m_diff = 2'd1, m_nd;
   logic m_chg = 1'b0, m_all;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         smp.delete();
         ev.delete();
         m_level = '0;
         m_prev = '0;
         m_diff = 2'd1;
         m_chg = 1'b0;
      end else begin
         m_pr = m_level & ~m_prev;
         m_nd = m_diff;
         if (game_state == 32'd0)
            for (int b = 4; b >= 0; b--)
               if (m_pr[b])
                  case (b)
                     0: m_nd = 2'd1;
                     1: m_nd = 2'd2;
                     2: m_nd = 2'd3;
                     3: m_nd = (m_diff == 2'd3) ? 2'd3 : m_diff + 2'd1;
                     default: m_nd = (m_diff == 2'd1) ? 2'd1 : m_diff - 2'd1;
                  endcase
         m_chg = m_nd != m_diff;
         m_diff = m_nd;
         m_prev = m_level;
         if (smp.size() >= 2) ev.push_back(smp[smp.size()-2]);
         else ev.push_back(5'd0);
         smp.push_back(btn_raw);
         if (smp.size() > 2) void'(smp.pop_front());
         if (ev.size() > D) void'(ev.pop_front());
         if (ev.size() == D)
            for (int b = 0; b < 5; b++) begin
               m_all = 1'b1;
               for (int k = 0; k < D; k++) if (ev[k][b] == m_level[b]) m_all = 1'b0;
               if (m_all) m_level[b] = ~m_level[b];
            end
      end
   end

   wire [42:0] act = {difficulty, btn_level, press_pulse, difficulty_changed};
   wire [42:0] exp_v = {30'd0, m_diff, m_level, m_level & ~m_prev, m_chg};

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      rst = 1; btn_raw = '0; game_state = '0;
      tick(2);
      n_chk++;
      if (act !== {32'd1, 5'd0, 5'd0, 1'b0}) begin n_fail++; $display("FAIL reset_hold: got %h expected %h", act, {32'd1, 11'd0}); end
      rst = 0;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         n_chk++;
         if (act !== {32'd1, 11'd0} || act !== exp_v) begin n_fail++; $display("FAIL reset_idle: got %h expected %h", act, {32'd1, 11'd0}); end
      end
      btn_raw = 5'b00010;
      tick(4);
      rst = 1;
      #1;
      n_chk++;
      if (btn_level !== 5'd0 || difficulty !== 32'd1) begin n_fail++; $display("FAIL reset_async: got level %b diff %0d expected 0/1", btn_level, difficulty); end
      tick(1);
      rst = 0;
      for (int i = 1; i <= 6; i++) begin
         tick(1);
         n_chk++;
         if (btn_level[1] !== (i == 6) || act !== exp_v) begin n_fail++; $display("FAIL reset_midcount tick %0d: got %h expected %h", i, act, exp_v); end
      end
      btn_raw = '0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         n_chk++;
         if (act !== exp_v) begin n_fail++; $display("FAIL reset_release: got %h expected %h", act, exp_v); end
      end
   endtask

   task automatic test_r_latency;
      btn_raw = 5'b00100;
      for (int i = 1; i <= 8; i++) begin
         tick(1);
         n_chk++;
         if (btn_level[2] !== (i >= 6) || press_pulse[2] !== (i == 6) ||
             difficulty !== ((i >= 7) ? 32'd3 : 32'd2) || difficulty_changed !== (i == 7) || act !== exp_v) begin
            n_fail++; $display("FAIL r_latency tick %0d: got %h expected %h", i, act, exp_v);
         end
      end
      btn_raw = '0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         n_chk++;
         if (press_pulse !== 5'd0 || act !== exp_v) begin n_fail++; $display("FAIL r_release: got %h expected %h", act, exp_v); end
      end
   endtask

   task automatic test_glitch;
      btn_raw = 5'b00010;
      for (int i = 0; i < 13; i++) begin
         if (i == 3) btn_raw = '0;
         tick(1);
         n_chk++;
         if (btn_level !== 5'd0 || press_pulse !== 5'd0 || difficulty !== 32'd3 || act !== exp_v) begin
            n_fail++; $display("FAIL glitch: got %h expected %h", act, exp_v);
         end
      end
   endtask

   task automatic test_step;
      logic [4:0] mask [4] = '{5'b01000, 5'b10000, 5'b10000, 5'b10000};
      logic [31:0] want [4] = '{32'd3, 32'd2, 32'd1, 32'd1};
      int pulses [4] = '{0, 1, 1, 0};
      int seen;
      for (int p = 0; p < 4; p++) begin
         seen = 0;
         btn_raw = mask[p];
         for (int i = 0; i < 18; i++) begin
            if (i == 8) btn_raw = '0;
            tick(1);
            seen += int'(difficulty_changed);
            n_chk++;
            if (act !== exp_v) begin n_fail++; $display("FAIL step_track %0d: got %h expected %h", p, act, exp_v); end
         end
         n_chk++;
         if (difficulty !== want[p] || seen != pulses[p]) begin
            n_fail++; $display("FAIL step %0d: got diff %0d changed %0d expected diff %0d changed %0d", p, difficulty, seen, want[p], pulses[p]);
         end
      end
   endtask

   task automatic test_priority;
      int cnt_l;
      btn_raw = 5'b00010;
      tick(8);
      btn_raw = '0;
      tick(10);
      n_chk++;
      if (difficulty !== 32'd2) begin n_fail++; $display("FAIL prio_setup: got %0d expected 2", difficulty); end
      cnt_l = 0;
      btn_raw = 5'b00101;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         cnt_l += int'(press_pulse[0]);
         n_chk++;
         if (act !== exp_v) begin n_fail++; $display("FAIL prio_track: got %h expected %h", act, exp_v); end
      end
      n_chk++;
      if (difficulty !== 32'd1 || cnt_l != 1) begin n_fail++; $display("FAIL prio_l_wins: got diff %0d pulses %0d expected 1/1", difficulty, cnt_l); end
      btn_raw = '0;
      tick(10);
   endtask

   task automatic test_idle_gate;
      int cnt_c;
      cnt_c = 0;
      game_state = 32'd5;
      btn_raw = 5'b00010;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         cnt_c += int'(press_pulse[1]);
      end
      n_chk++;
      if (cnt_c != 1 || difficulty !== 32'd1 || difficulty_changed !== 1'b0) begin
         n_fail++; $display("FAIL gate_busy: got pulses %0d diff %0d expected 1/1", cnt_c, difficulty);
      end
      game_state = '0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         n_chk++;
         if (difficulty !== 32'd1 || press_pulse !== 5'd0 || act !== exp_v) begin n_fail++; $display("FAIL gate_held: got %h expected %h", act, exp_v); end
      end
      btn_raw = '0;
      tick(10);
      btn_raw = 5'b00010;
      tick(8);
      btn_raw = '0;
      tick(10);
      n_chk++;
      if (difficulty !== 32'd2) begin n_fail++; $display("FAIL gate_repress: got %0d expected 2", difficulty); end
   endtask

   task automatic test_random;
      int len;
      for (int r = 0; r < 400; r++) begin
         btn_raw = 5'($urandom);
         game_state = ($urandom_range(0, 3) == 0) ? 32'd5 : 32'd0;
         len = $urandom_range(1, 8);
         for (int i = 0; i < len; i++) begin
            tick(1);
            n_chk++;
            if (act !== exp_v) begin n_fail++; $display("FAIL random run %0d: got %h expected %h", r, act, exp_v); end
         end
      end
      btn_raw = '0;
      game_state = '0;
      tick(10);
   endtask

   initial begin
      test_reset();
      test_r_latency();
      test_glitch();
      test_step();
      test_priority();
      test_idle_gate();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
